// File: rtl/pc_pkg.sv
// Shared types and constants for the PC fetch controller.
// State encoding, adder select codes and the default reset PC.
package pc_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_FULL,
        S_FAULT
    } state_t;

    localparam logic [1:0] PC_SRC_SEQ = 2'b00;
    localparam logic [1:0] PC_SRC_BR  = 2'b01;
    localparam logic [1:0] PC_SRC_JMP = 2'b10;

    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_timer.sv
// Counts consecutive enabled cycles; expire fires on the LIMIT-th one.
// Any cycle with en low clears the count.
module fetch_timer #(
    parameter int unsigned LIMIT = 16
) (
    input  logic CLK,
    input  logic RST,
    input  logic en,
    output logic expire
);

    localparam int unsigned W = (LIMIT < 2) ? 1 : $clog2(LIMIT);

    logic [W-1:0] cnt;

    always_ff @(posedge CLK) begin
        if (!RST || !en) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expire = en && (cnt == W'(LIMIT - 1));

endmodule

// File: rtl/pc_fetch_ctrl.sv
// PC sequencing and instruction fetch control with an external PC adder.
// Optional PCCTRL_ALIGN_CHECK_EN faults on misaligned redirect targets.
module pc_fetch_ctrl
    import pc_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = PC_RESET_DEFAULT,
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic        CLK,
    input  logic        RST,
    output logic [1:0]  pc_src,
    output logic [31:0] pc_offset,
    output logic [31:0] cur_pc,
    input  logic [31:0] next_pc,
    input  logic        br_req,
    input  logic [31:0] br_offset,
    input  logic        jmp_req,
    input  logic [15:0] jmp_index,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic        fault
);

    state_t state;
    logic   active;
    logic   redirect;
    logic   tmr_en;
    logic   expire;

    assign active    = (state != S_IDLE) && (state != S_FAULT);
    assign redirect  = active && (br_req || jmp_req);
    assign imem_req  = (state == S_REQ) || (state == S_WAIT);
    assign imem_addr = cur_pc;
    assign tmr_en    = (state == S_WAIT) && !imem_ack && !redirect;

    always_comb begin
        pc_src    = PC_SRC_SEQ;
        pc_offset = '0;
        if (active && jmp_req) begin
            pc_src    = PC_SRC_JMP;
            pc_offset = {16'b0, jmp_index};
        end else if (active && br_req) begin
            pc_src    = PC_SRC_BR;
            pc_offset = br_offset;
        end
    end

    fetch_timer #(
        .LIMIT (ACK_TIMEOUT)
    ) u_timer (
        .CLK    (CLK),
        .RST    (RST),
        .en     (tmr_en),
        .expire (expire)
    );

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state       <= S_IDLE;
            cur_pc      <= RESET_PC;
            instr       <= '0;
            instr_valid <= 1'b0;
            fault       <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: state <= S_REQ;
                S_FAULT: begin
                    instr_valid <= 1'b0;
                end
                default: begin
                    // a redirect wins over a coincident ack: the word is dropped
                    if (redirect) begin
`ifdef PCCTRL_ALIGN_CHECK_EN
                        if (next_pc[1:0] != 2'b00) begin
                            state       <= S_FAULT;
                            fault       <= 1'b1;
                            instr_valid <= 1'b0;
                        end else
`endif
                        begin
                            cur_pc      <= next_pc;
                            instr_valid <= 1'b0;
                            state       <= S_REQ;
                        end
                    end else if (imem_req && imem_ack) begin
                        instr       <= imem_rdata;
                        instr_valid <= 1'b1;
                        cur_pc      <= next_pc;
                        state       <= instr_ready ? S_REQ : S_FULL;
                    end else if (expire) begin
                        state       <= S_FAULT;
                        fault       <= 1'b1;
                        instr_valid <= 1'b0;
                    end else begin
                        if (instr_ready) begin
                            instr_valid <= 1'b0;
                        end
                        if (state == S_FULL && instr_ready) begin
                            state <= S_REQ;
                        end else if (state == S_REQ) begin
                            state <= S_WAIT;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl with an external adder and a
// combinational instruction memory (rdata = addr ^ 32'hDEAD_0000).
module tb_pc_fetch_ctrl;

    localparam int unsigned TO = 16;
    localparam logic [31:0] MASK = 32'hDEAD_0000;

    logic        CLK = 1'b0;
    logic        RST;
    logic [1:0]  pc_src;
    logic [31:0] pc_offset;
    logic [31:0] cur_pc;
    logic [31:0] next_pc;
    logic        br_req;
    logic [31:0] br_offset;
    logic        jmp_req;
    logic [15:0] jmp_index;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        fault;

    int n_chk = 0;
    int n_fail = 0;

    always #5 CLK = ~CLK;

    pc_fetch_ctrl #(
        .RESET_PC    (32'h0),
        .ACK_TIMEOUT (TO)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .pc_src      (pc_src),
        .pc_offset   (pc_offset),
        .cur_pc      (cur_pc),
        .next_pc     (next_pc),
        .br_req      (br_req),
        .br_offset   (br_offset),
        .jmp_req     (jmp_req),
        .jmp_index   (jmp_index),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .fault       (fault)
    );

    // external adder
    always_comb begin
        case (pc_src)
            2'b01:   next_pc = cur_pc + 32'd4 + pc_offset;
            2'b10:   next_pc = {14'b0, pc_offset[15:0], 2'b00};
            default: next_pc = cur_pc + 32'd4;
        endcase
    end

    always_comb imem_rdata = imem_addr ^ MASK;

    typedef struct {
        logic        rst;
        logic        ack;
        logic        rdy;
        logic        br;
        logic        jmp;
        logic [31:0] boff;
        logic [15:0] jidx;
        logic [31:0] e_pc;
        logic        e_req;
        logic        e_val;
        logic [31:0] e_instr;
        logic        e_fault;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic ack, input logic rdy,
                       input logic br, input logic jmp, input logic [31:0] boff,
                       input logic [15:0] jidx, input logic [31:0] e_pc,
                       input logic e_req, input logic e_val,
                       input logic [31:0] e_instr, input logic e_fault);
        vec_t v;
        v.rst = rst; v.ack = ack; v.rdy = rdy; v.br = br; v.jmp = jmp;
        v.boff = boff; v.jidx = jidx; v.e_pc = e_pc; v.e_req = e_req;
        v.e_val = e_val; v.e_instr = e_instr; v.e_fault = e_fault;
        vq.push_back(v);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic rst, input logic ack, input logic rdy,
                         input logic br, input logic jmp,
                         input logic [31:0] boff, input logic [15:0] jidx);
        RST = rst; imem_ack = ack; instr_ready = rdy;
        br_req = br; jmp_req = jmp; br_offset = boff; jmp_index = jidx;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        logic [1:0] esrc;
        drive(0, 0, 0, 0, 0, 0, 0);

        // reset, then streaming fetch with ack and ready tied high
        add(0,0,0,0,0,0,0,        32'h0,   0,0,32'h0,       0);
        add(1,1,1,0,0,0,0,        32'h0,   1,0,32'h0,       0);
        add(1,1,1,0,0,0,0,        32'h4,   1,1,32'hDEAD0000,0);
        add(1,1,1,0,0,0,0,        32'h8,   1,1,32'hDEAD0004,0);
        add(1,1,1,0,0,0,0,        32'hC,   1,1,32'hDEAD0008,0);
        add(1,1,1,0,0,0,0,        32'h10,  1,1,32'hDEAD000C,0);
        // back-pressure: ready low for 3 cycles from the first ack
        add(0,1,1,0,0,0,0,        32'h0,   0,0,32'h0,       0);
        add(1,1,0,0,0,0,0,        32'h0,   1,0,32'h0,       0);
        add(1,1,0,0,0,0,0,        32'h4,   0,1,32'hDEAD0000,0);
        add(1,1,0,0,0,0,0,        32'h4,   0,1,32'hDEAD0000,0);
        add(1,1,0,0,0,0,0,        32'h4,   0,1,32'hDEAD0000,0);
        add(1,1,1,0,0,0,0,        32'h4,   1,0,32'hDEAD0000,0);
        add(1,1,1,0,0,0,0,        32'h8,   1,1,32'hDEAD0004,0);
        // branch coincident with ack at pc 8
        add(1,1,1,1,0,32'h10,0,   32'h1C,  1,0,32'hDEAD0004,0);
        add(1,1,1,0,0,0,0,        32'h20,  1,1,32'hDEAD001C,0);
        // jump wins over branch
        add(1,1,1,1,1,32'h10,16'h40, 32'h100, 1,0,32'hDEAD001C,0);
        // redirect from WAIT, then capture into FULL, then jump from FULL
        add(1,0,1,0,0,0,0,        32'h100, 1,0,32'hDEAD001C,0);
        add(1,0,1,1,0,32'h20,0,   32'h124, 1,0,32'hDEAD001C,0);
        add(1,1,0,0,0,0,0,        32'h128, 0,1,32'hDEAD0124,0);
        add(1,0,0,0,1,0,16'h10,   32'h40,  1,0,32'hDEAD0124,0);
        // wrap of 0xFFFF_FFFC + 4
        add(1,1,1,1,0,32'hFFFF_FFB8,0, 32'hFFFF_FFFC, 1,0,32'hDEAD0124,0);
        add(1,1,1,0,0,0,0,        32'h0,   1,1,32'h2152_FFFC,0);
`ifdef PCCTRL_ALIGN_CHECK_EN
        add(1,0,1,1,0,32'h2,0,    32'h0,   0,0,32'h2152_FFFC,1);
`else
        add(1,0,1,1,0,32'h2,0,    32'h6,   1,0,32'h2152_FFFC,0);
`endif
        add(0,0,1,0,0,0,0,        32'h0,   0,0,32'h0,       0);

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].rst, vq[i].ack, vq[i].rdy, vq[i].br, vq[i].jmp,
                  vq[i].boff, vq[i].jidx);
            #1;
            esrc = vq[i].jmp ? 2'b10 : (vq[i].br ? 2'b01 : 2'b00);
            chk($sformatf("v%0d pc_src", i), {30'b0, pc_src}, {30'b0, esrc});
            step();
            chk($sformatf("v%0d cur_pc", i), cur_pc, vq[i].e_pc);
            chk($sformatf("v%0d imem_addr", i), imem_addr, vq[i].e_pc);
            chk($sformatf("v%0d imem_req", i), {31'b0, imem_req}, {31'b0, vq[i].e_req});
            chk($sformatf("v%0d instr_valid", i), {31'b0, instr_valid}, {31'b0, vq[i].e_val});
            chk($sformatf("v%0d instr", i), instr, vq[i].e_instr);
            chk($sformatf("v%0d fault", i), {31'b0, fault}, {31'b0, vq[i].e_fault});
        end

        // ack timeout
        drive(1, 0, 1, 0, 0, 0, 0);
        step();
        chk("to start req", {31'b0, imem_req}, 32'd1);
        n = 0;
        while (!fault && n < 40) begin
            step();
            n++;
        end
        chk("to fault set", {31'b0, fault}, 32'd1);
        n_chk++;
        if (n < TO || n > TO + 2) begin
            n_fail++;
            $display("FAIL to cycles: got %0d expected %0d..%0d", n, TO, TO + 2);
        end
        chk("to imem_req", {31'b0, imem_req}, 32'd0);
        chk("to instr_valid", {31'b0, instr_valid}, 32'd0);

        // inputs ignored while faulted
        drive(1, 1, 1, 1, 1, 32'h40, 16'h80);
        step();
        step();
        chk("flt sticky", {31'b0, fault}, 32'd1);
        chk("flt pc", cur_pc, 32'h0);
        chk("flt req", {31'b0, imem_req}, 32'd0);

        // one-cycle reset clears the fault, fetch resumes at RESET_PC
        drive(0, 1, 1, 1, 0, 32'h40, 0);
        step();
        chk("rst fault", {31'b0, fault}, 32'd0);
        chk("rst pc", cur_pc, 32'h0);
        drive(1, 1, 1, 0, 0, 0, 0);
        step();
        chk("rst req", {31'b0, imem_req}, 32'd1);
        step();
        chk("rst fetch pc", cur_pc, 32'h4);
        chk("rst fetch instr", instr, 32'hDEAD0000);
        chk("rst fetch valid", {31'b0, instr_valid}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
